// File: rtl/duck_game_fsm_if.sv
// Game-sequencer bus: player/sprite event inputs and HUD/dog-state outputs.
// The sequencer takes the slave side; whatever drives the events is the master.
interface duck_game_fsm_if;
    logic       frame_clk;
    logic       start;
    logic       trigger;
    logic       hit;
    logic       bird_landed;
    logic       bird_escaped;
    logic       dog_start;
    logic       dog_duck;
    logic [2:0] state;
    logic       new_round;
    logic [1:0] shells;
    logic [3:0] round_num;
    logic [1:0] misses;
    logic [15:0] score;

    modport master (
        output frame_clk, start, trigger, hit, bird_landed, bird_escaped, dog_start, dog_duck,
        input  state, new_round, shells, round_num, misses, score
    );

    modport slave (
        input  frame_clk, start, trigger, hit, bird_landed, bird_escaped, dog_start, dog_duck,
        output state, new_round, shells, round_num, misses, score
    );
endinterface

// File: rtl/duck_game_fsm.sv
// Round/game sequencer for the duck-hunt video pipeline. Drives the 3-bit
// state code decoded by the dog sprite block and keeps shells, rounds,
// misses and a saturating score for the HUD.
module duck_game_fsm #(
    parameter int MAX_ROUNDS    = 10,
    parameter int MAX_MISSES    = 3,
    parameter int SHELLS        = 3,
    parameter int FLY_FRAMES    = 300,
    parameter int ESCAPE_FRAMES = 90,
    parameter int POINTS        = 500
) (
    input  logic             Clk,
    input  logic             Reset_n,
    duck_game_fsm_if.slave   bus
);

    // Encoding is shared with the dog block and must not change.
    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        FLY        = 3'b001,
        ROUND_INIT = 3'b010,
        SHOT       = 3'b011,
        ESCAPE     = 3'b100,
        DOG_SHOW   = 3'b101,
        DOG_INTRO  = 3'b110,
        GAME_OVER  = 3'b111
    } game_state_e;

    localparam logic [9:0]  FLY_LAST    = 10'(FLY_FRAMES - 1);
    localparam logic [9:0]  ESC_LAST    = 10'(ESCAPE_FRAMES - 1);
    localparam logic [1:0]  SHELLS_INIT = 2'(SHELLS);
    localparam logic [1:0]  MISS_MAX    = 2'(MAX_MISSES);
    localparam logic [3:0]  ROUND_MAX   = 4'(MAX_ROUNDS);
    localparam logic [16:0] POINTS_W    = 17'(POINTS);

    game_state_e state_q, state_d;
    logic [9:0]  timer_q, timer_d;
    logic [1:0]  shells_q, shells_d;
    logic [3:0]  round_q, round_d;
    logic [1:0]  misses_q, misses_d;
    logic [15:0] score_q, score_d;
    logic        new_round_q, new_round_d;
    logic [2:0]  sync_q;

    logic        tick;
    logic        fire;
    logic        fly_timeout;
    logic        esc_done;
    logic        last_round;
    logic [1:0]  misses_inc;
    logic [16:0] score_sum;
    logic [15:0] score_sat;

    // frame_clk is asynchronous: two flops resynchronise it, the third gives edge detect.
    assign tick        = sync_q[1] & ~sync_q[2];
    assign fire        = bus.trigger && (shells_q != 2'd0);
    assign fly_timeout = tick && (timer_q == FLY_LAST);
    assign esc_done    = tick && (timer_q == ESC_LAST);
    assign last_round  = (round_q == ROUND_MAX);
    assign misses_inc  = (misses_q == MISS_MAX) ? misses_q : misses_q + 2'd1;
    assign score_sum   = {1'b0, score_q} + POINTS_W;
    assign score_sat   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // State register plus every counter that follows the state machine.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            shells_q    <= '0;
            round_q     <= '0;
            misses_q    <= '0;
            score_q     <= '0;
            new_round_q <= 1'b0;
            sync_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state_q     <= state_d;
            timer_q     <= timer_d;
            shells_q    <= shells_d;
            round_q     <= round_d;
            misses_q    <= misses_d;
            score_q     <= score_d;
            new_round_q <= new_round_d;
            sync_q      <= {sync_q[1:0], bus.frame_clk};
        end
    end

    // Next-state decision; round end is folded into DOG_SHOW and ESCAPE exits.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.start) state_d = ROUND_INIT;
            ROUND_INIT: if (tick) state_d = DOG_INTRO;
            DOG_INTRO:  if (bus.dog_start) state_d = FLY;
            FLY: begin
                if (fire && bus.hit)
                    state_d = SHOT;
                else if ((fire && shells_q == 2'd1) || bus.bird_escaped || fly_timeout)
                    state_d = ESCAPE;
            end
            SHOT:       if (bus.bird_landed) state_d = DOG_SHOW;
            DOG_SHOW:   if (bus.dog_duck) state_d = last_round ? GAME_OVER : ROUND_INIT;
            ESCAPE: begin
                if (esc_done)
                    state_d = (misses_inc == MISS_MAX || last_round) ? GAME_OVER : ROUND_INIT;
            end
            GAME_OVER:  if (bus.start) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Counter and pulse updates driven by the current state and the chosen transition.
    always_comb begin
        timer_d     = timer_q;
        shells_d    = shells_q;
        round_d     = round_q;
        misses_d    = misses_q;
        score_d     = score_q;
        new_round_d = 1'b0;

        if (state_d != state_q)
            timer_d = '0;
        else if (tick && (state_q == FLY || state_q == ESCAPE))
            timer_d = timer_q + 10'd1;

        if (state_q == IDLE && bus.start) begin
            score_d  = '0;
            misses_d = '0;
            round_d  = 4'd1;
        end

        if (state_q == FLY && fire) begin
            shells_d = shells_q - 2'd1;
            if (bus.hit)
                score_d = score_sat;
        end

        if (state_q == ESCAPE && esc_done)
            misses_d = misses_inc;

        // Any entry to ROUND_INIT reloads shells; only a round end (not a new game) advances the round.
        if (state_d == ROUND_INIT && state_q != ROUND_INIT) begin
            shells_d    = SHELLS_INIT;
            new_round_d = 1'b1;
            if (state_q != IDLE)
                round_d = round_q + 4'd1;
        end
    end

    assign bus.state     = state_q;
    assign bus.new_round = new_round_q;
    assign bus.shells    = shells_q;
    assign bus.round_num = round_q;
    assign bus.misses    = misses_q;
    assign bus.score     = score_q;

endmodule

// File: tb/tb_duck_game_fsm.sv
// Self-checking bench for duck_game_fsm. A scoreboard queue holds the
// expected outputs for each state change of the default-parameter instance;
// a second instance with two rounds and large POINTS covers score saturation.
module tb_duck_game_fsm;

    localparam logic [2:0] S_IDLE = 3'b000, S_FLY = 3'b001, S_RI = 3'b010, S_SHOT = 3'b011,
                           S_ESC = 3'b100, S_DS = 3'b101, S_DI = 3'b110, S_GO = 3'b111;

    typedef struct {
        logic [2:0]  state;
        logic [1:0]  shells;
        logic [3:0]  round_num;
        logic [1:0]  misses;
        logic [15:0] score;
    } exp_t;

    logic Clk       = 1'b0;
    logic Reset_n   = 1'b1;
    logic frame_clk = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    exp_t mon_e;
    logic [2:0] prev_state = 3'b000;
    logic [2:0] fr_q = 3'b000;
    logic tb_tick;

    duck_game_fsm_if bus0();
    duck_game_fsm_if bus1();
    assign bus0.frame_clk = frame_clk;
    assign bus1.frame_clk = frame_clk;

    duck_game_fsm dut0 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus0.slave));
    duck_game_fsm #(.MAX_ROUNDS(2), .POINTS(40000)) dut1 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus1.slave));

    always #10 Clk = ~Clk;
    initial begin
        #5;
        forever #80 frame_clk = ~frame_clk;
    end

    // Reference frame tick: frame_clk registered twice, pulse on the rising edge.
    always @(posedge Clk) fr_q <= {fr_q[1:0], frame_clk};
    assign tb_tick = fr_q[1] & ~fr_q[2];

    // Scoreboard monitor: every state change of dut0 pops one expectation.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_state <= S_IDLE;
        end else if (bus0.state !== prev_state) begin
            prev_state <= bus0.state;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: state went %b -> %b with nothing expected", prev_state, bus0.state);
            end else begin
                mon_e = sb.pop_front();
                if (bus0.state !== mon_e.state) begin
                    failures++;
                    $display("FAIL sb_state: got %b want %b", bus0.state, mon_e.state);
                end
                checks++;
                if (bus0.shells !== mon_e.shells) begin
                    failures++;
                    $display("FAIL sb_shells (state %b): got %0d want %0d", mon_e.state, bus0.shells, mon_e.shells);
                end
                checks++;
                if (bus0.round_num !== mon_e.round_num) begin
                    failures++;
                    $display("FAIL sb_round (state %b): got %0d want %0d", mon_e.state, bus0.round_num, mon_e.round_num);
                end
                checks++;
                if (bus0.misses !== mon_e.misses) begin
                    failures++;
                    $display("FAIL sb_misses (state %b): got %0d want %0d", mon_e.state, bus0.misses, mon_e.misses);
                end
                checks++;
                if (bus0.score !== mon_e.score) begin
                    failures++;
                    $display("FAIL sb_score (state %b): got %0d want %0d", mon_e.state, bus0.score, mon_e.score);
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] st, input logic [1:0] sh, input logic [3:0] rn,
                            input logic [1:0] ms, input logic [15:0] sc);
        exp_t e;
        e.state = st; e.shells = sh; e.round_num = rn; e.misses = ms; e.score = sc;
        sb.push_back(e);
    endtask

    task automatic set_in(input int which, input logic st, input logic tr, input logic hi,
                          input logic bl, input logic be, input logic ds, input logic dd);
        if (which == 0) begin
            bus0.start = st; bus0.trigger = tr; bus0.hit = hi; bus0.bird_landed = bl;
            bus0.bird_escaped = be; bus0.dog_start = ds; bus0.dog_duck = dd;
        end else begin
            bus1.start = st; bus1.trigger = tr; bus1.hit = hi; bus1.bird_landed = bl;
            bus1.bird_escaped = be; bus1.dog_start = ds; bus1.dog_duck = dd;
        end
    endtask

    // One-cycle pulse; returns 2 ns after the capturing edge.
    task automatic pulse(input int which, input logic st, input logic tr, input logic hi,
                         input logic bl, input logic be, input logic ds, input logic dd);
        @(posedge Clk); #2;
        set_in(which, st, tr, hi, bl, be, ds, dd);
        @(posedge Clk); #2;
        set_in(which, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [2:0] cur_state(input int which);
        return (which == 0) ? bus0.state : bus1.state;
    endfunction

    // Waits (bounded) until the state leaves 'from', counting ticks consumed meanwhile.
    task automatic wait_leave(input int which, input logic [2:0] from, input int budget, output int ticks);
        int n = 0;
        ticks = 0;
        forever begin
            if (cur_state(which) !== from) break;
            if (n >= budget) begin
                checks++; failures++;
                $display("FAIL wait_leave: stuck in %b after %0d cycles", from, budget);
                break;
            end
            if (tb_tick) ticks++;
            @(posedge Clk); #2;
            n++;
        end
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #3 Reset_n = 1'b0;
        #4;
        checks++; if (bus0.state !== 3'b000) begin failures++; $display("FAIL reset_state: got %b want 000", bus0.state); end
        checks++; if (bus0.shells !== 2'd0) begin failures++; $display("FAIL reset_shells: got %0d want 0", bus0.shells); end
        checks++; if (bus0.round_num !== 4'd0) begin failures++; $display("FAIL reset_round: got %0d want 0", bus0.round_num); end
        checks++; if (bus0.misses !== 2'd0) begin failures++; $display("FAIL reset_misses: got %0d want 0", bus0.misses); end
        checks++; if (bus0.score !== 16'd0) begin failures++; $display("FAIL reset_score: got %0d want 0", bus0.score); end
        checks++; if (bus0.new_round !== 1'b0) begin failures++; $display("FAIL reset_new_round: got %b want 0", bus0.new_round); end
        repeat (3) @(posedge Clk);
        #5 Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (bus0.state !== S_IDLE) begin failures++; $display("FAIL idle_hold: got %b want 000", bus0.state); end
    endtask

    task automatic test_start_round();
        int t;
        push_exp(S_RI, 2'd3, 4'd1, 2'd0, 16'd0);
        pulse(0, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (bus0.new_round !== 1'b1) begin failures++; $display("FAIL new_round_on: got %b want 1", bus0.new_round); end
        @(posedge Clk); #2;
        checks++; if (bus0.new_round !== 1'b0) begin failures++; $display("FAIL new_round_off: got %b want 0", bus0.new_round); end
        push_exp(S_DI, 2'd3, 4'd1, 2'd0, 16'd0);
        wait_leave(0, S_RI, 40, t);
    endtask

    task automatic test_hit_round();
        int t;
        push_exp(S_FLY, 2'd3, 4'd1, 2'd0, 16'd0);
        pulse(0, 0, 0, 0, 0, 0, 1, 0);
        push_exp(S_SHOT, 2'd2, 4'd1, 2'd0, 16'd500);
        pulse(0, 0, 1, 1, 0, 0, 0, 0);
        pulse(0, 0, 1, 1, 0, 0, 0, 0);   // trigger in SHOT is ignored
        pulse(0, 0, 0, 0, 0, 0, 1, 1);   // dog pulses outside their state are ignored
        checks++; if (bus0.state !== S_SHOT || bus0.shells !== 2'd2) begin
            failures++; $display("FAIL shot_ignore: state %b shells %0d want 011 shells 2", bus0.state, bus0.shells);
        end
        push_exp(S_DS, 2'd2, 4'd1, 2'd0, 16'd500);
        pulse(0, 0, 0, 0, 1, 0, 0, 0);
        push_exp(S_RI, 2'd3, 4'd2, 2'd0, 16'd500);
        pulse(0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus0.new_round !== 1'b1) begin failures++; $display("FAIL new_round_round2: got %b want 1", bus0.new_round); end
        push_exp(S_DI, 2'd3, 4'd2, 2'd0, 16'd500);
        wait_leave(0, S_RI, 40, t);
    endtask

    task automatic test_shells_out();
        int t;
        push_exp(S_FLY, 2'd3, 4'd2, 2'd0, 16'd500);
        pulse(0, 0, 0, 0, 0, 0, 1, 0);
        pulse(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (bus0.shells !== 2'd2) begin failures++; $display("FAIL miss1_shells: got %0d want 2", bus0.shells); end
        pulse(0, 0, 0, 1, 0, 0, 0, 0);   // hit without trigger
        checks++; if (bus0.shells !== 2'd2) begin failures++; $display("FAIL hit_only_shells: got %0d want 2", bus0.shells); end
        pulse(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (bus0.shells !== 2'd1 || bus0.state !== S_FLY) begin
            failures++; $display("FAIL miss2: shells %0d state %b want 1 001", bus0.shells, bus0.state);
        end
        push_exp(S_ESC, 2'd0, 4'd2, 2'd0, 16'd500);
        pulse(0, 0, 1, 0, 0, 0, 0, 0);
        push_exp(S_RI, 2'd3, 4'd3, 2'd1, 16'd500);
        wait_leave(0, S_ESC, 1500, t);
        checks++; if (t != 90) begin failures++; $display("FAIL escape_ticks: got %0d want 90", t); end
        push_exp(S_DI, 2'd3, 4'd3, 2'd1, 16'd500);
        wait_leave(0, S_RI, 40, t);
    endtask

    task automatic test_fly_timeout();
        int t;
        push_exp(S_FLY, 2'd3, 4'd3, 2'd1, 16'd500);
        pulse(0, 0, 0, 0, 0, 0, 1, 0);
        push_exp(S_ESC, 2'd3, 4'd3, 2'd1, 16'd500);
        wait_leave(0, S_FLY, 4000, t);
        checks++; if (t != 300) begin failures++; $display("FAIL fly_ticks: got %0d want 300", t); end
        push_exp(S_RI, 2'd3, 4'd4, 2'd2, 16'd500);
        wait_leave(0, S_ESC, 1500, t);
        push_exp(S_DI, 2'd3, 4'd4, 2'd2, 16'd500);
        wait_leave(0, S_RI, 40, t);
    endtask

    task automatic test_hit_on_timeout();
        int t;
        int ticks = 0;
        int n = 0;
        push_exp(S_FLY, 2'd3, 4'd4, 2'd2, 16'd500);
        pulse(0, 0, 0, 0, 0, 0, 1, 0);
        while (n < 4000) begin
            if (tb_tick) begin
                ticks++;
                if (ticks == 300) break;
            end
            @(posedge Clk); #2;
            n++;
        end
        checks++; if (ticks != 300) begin failures++; $display("FAIL tick300_reach: got %0d want 300", ticks); end
        push_exp(S_SHOT, 2'd2, 4'd4, 2'd2, 16'd1000);
        set_in(0, 0, 1, 1, 0, 0, 0, 0);
        @(posedge Clk); #2;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus0.state !== S_SHOT) begin failures++; $display("FAIL hit_wins_timeout: got %b want 011", bus0.state); end
        push_exp(S_DS, 2'd2, 4'd4, 2'd2, 16'd1000);
        pulse(0, 0, 0, 0, 1, 0, 0, 0);
        push_exp(S_RI, 2'd3, 4'd5, 2'd2, 16'd1000);
        pulse(0, 0, 0, 0, 0, 0, 0, 1);
        push_exp(S_DI, 2'd3, 4'd5, 2'd2, 16'd1000);
        wait_leave(0, S_RI, 40, t);
    endtask

    task automatic test_game_over();
        int t;
        push_exp(S_FLY, 2'd3, 4'd5, 2'd2, 16'd1000);
        pulse(0, 0, 0, 0, 0, 0, 1, 0);
        pulse(0, 1, 0, 0, 0, 0, 0, 0);   // start ignored in FLY
        checks++; if (bus0.state !== S_FLY) begin failures++; $display("FAIL start_in_fly: got %b want 001", bus0.state); end
        push_exp(S_ESC, 2'd3, 4'd5, 2'd2, 16'd1000);
        pulse(0, 0, 0, 0, 0, 1, 0, 0);
        push_exp(S_GO, 2'd3, 4'd5, 2'd3, 16'd1000);
        wait_leave(0, S_ESC, 1500, t);
        pulse(0, 0, 1, 1, 0, 0, 1, 0);
        checks++; if (bus0.state !== S_GO || bus0.misses !== 2'd3 || bus0.score !== 16'd1000) begin
            failures++; $display("FAIL game_over_frozen: state %b misses %0d score %0d", bus0.state, bus0.misses, bus0.score);
        end
        push_exp(S_IDLE, 2'd3, 4'd5, 2'd3, 16'd1000);
        pulse(0, 1, 0, 0, 0, 0, 0, 0);
        push_exp(S_RI, 2'd3, 4'd1, 2'd0, 16'd0);
        pulse(0, 1, 0, 0, 0, 0, 0, 0);
        push_exp(S_DI, 2'd3, 4'd1, 2'd0, 16'd0);
        wait_leave(0, S_RI, 40, t);
    endtask

    task automatic test_reset_mid_fly();
        push_exp(S_FLY, 2'd3, 4'd1, 2'd0, 16'd0);
        pulse(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        checks++; if (bus0.state !== 3'b000) begin failures++; $display("FAIL async_state: got %b want 000", bus0.state); end
        checks++; if (bus0.shells !== 2'd0 || bus0.round_num !== 4'd0) begin
            failures++; $display("FAIL async_counts: shells %0d round %0d want 0 0", bus0.shells, bus0.round_num);
        end
        checks++; if (bus0.new_round !== 1'b0 || bus0.misses !== 2'd0) begin
            failures++; $display("FAIL async_misc: new_round %b misses %0d want 0 0", bus0.new_round, bus0.misses);
        end
        #20 Reset_n = 1'b1;
        @(negedge Clk);
        checks++; if (bus0.state !== S_IDLE) begin failures++; $display("FAIL post_reset_idle: got %b want 000", bus0.state); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drained: %0d left want 0", sb.size()); end
    endtask

    task automatic test_saturation();
        int t;
        pulse(1, 1, 0, 0, 0, 0, 0, 0);
        wait_leave(1, S_RI, 40, t);
        pulse(1, 0, 0, 0, 0, 0, 1, 0);
        pulse(1, 0, 1, 1, 0, 0, 0, 0);
        checks++; if (bus1.state !== S_SHOT || bus1.score !== 16'd40000) begin
            failures++; $display("FAIL sat_hit1: state %b score %0d want 011 40000", bus1.state, bus1.score);
        end
        pulse(1, 0, 0, 0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus1.state !== S_RI || bus1.round_num !== 4'd2) begin
            failures++; $display("FAIL sat_round2: state %b round %0d want 010 2", bus1.state, bus1.round_num);
        end
        wait_leave(1, S_RI, 40, t);
        pulse(1, 0, 0, 0, 0, 0, 1, 0);
        pulse(1, 0, 1, 1, 0, 0, 0, 0);
        checks++; if (bus1.score !== 16'hFFFF) begin failures++; $display("FAIL sat_clamp: got %0d want 65535", bus1.score); end
        pulse(1, 0, 0, 0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus1.state !== S_GO || bus1.round_num !== 4'd2) begin
            failures++; $display("FAIL last_round_over: state %b round %0d want 111 2", bus1.state, bus1.round_num);
        end
        pulse(1, 1, 0, 0, 0, 0, 0, 0);
        checks++; if (bus1.state !== S_IDLE || bus1.score !== 16'hFFFF) begin
            failures++; $display("FAIL sat_idle: state %b score %0d want 000 65535", bus1.state, bus1.score);
        end
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_round();
        test_hit_round();
        test_shells_out();
        test_fly_timeout();
        test_hit_on_timeout();
        test_game_over();
        test_reset_mid_fly();
        test_saturation();
        @(negedge Clk);
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_final: %0d left want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
